// File: rtl/fp16_pkg.sv
// Shared FP16 types and constants for the pipelined floating-point units.
// Tags pair a valid bit with the requester id that owns an in-flight operation.
package fp16_pkg;

    localparam int FP16_W          = 16;
    localparam int EXP_BIAS        = 15;
    localparam int DEFAULT_MUL_LAT = 4;

    typedef logic [FP16_W-1:0] fp16_t;
    typedef logic              req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/fp16_mult_arbiter_if.sv
// Requester-side bus of the shared multiplier: two operand channels in, one
// tagged result pulse out. Requesters use master, the arbiter uses slave.
interface fp16_mult_arbiter_if;
    import fp16_pkg::*;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    fp16_t      req_a0;
    fp16_t      req_b0;
    fp16_t      req_a1;
    fp16_t      req_b1;
    logic [1:0] resp_valid;
    fp16_t      resp_data;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/fp16_tag_pipe.sv
// Fixed-depth {valid, id} shift register that shadows a pipelined FP unit so
// each result can be matched to the requester that issued it.
module fp16_tag_pipe
    import fp16_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MUL_LAT
) (
    input  logic clock,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stages [DEPTH];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/fp16_mult_arbiter.sv
// Round-robin front end that shares one pipelined FP16 multiplier between two
// requesters and routes each product back to its owner in issue order.
module fp16_mult_arbiter
    import fp16_pkg::*;
#(
    parameter int MUL_LAT = DEFAULT_MUL_LAT,
    parameter int CNT_W   = 4
) (
    input  logic                clock,
    input  logic                rst_n,
    fp16_mult_arbiter_if.slave  req_bus,
    input  logic                hold,
    output logic                mul_valid,
    output fp16_t               mul_a,
    output fp16_t               mul_b,
    input  fp16_t               mul_result,
    output fp16_t               last_result,
    output logic [CNT_W-1:0]    inflight_cnt
);

    logic       rr_last;
    logic [1:0] grant;
    logic [1:0] accept;
    req_id_t    accept_id;
    req_id_t    issue_id;
    fp16_t      sel_a;
    fp16_t      sel_b;
    tag_t       tag_in;
    tag_t       tag_out;

    // On contention the requester that did not win last time goes next.
    always_comb begin
        grant = 2'b00;
        case (req_bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_bus.req_ready = grant & {2{~hold}};
    assign accept            = req_bus.req_valid & req_bus.req_ready;
    assign accept_id         = accept[1];
    assign sel_a             = accept_id ? req_bus.req_a1 : req_bus.req_a0;
    assign sel_b             = accept_id ? req_bus.req_b1 : req_bus.req_b0;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            issue_id  <= 1'b0;
            rr_last   <= 1'b1;
        end else begin
            mul_valid <= |accept;
            if (|accept) begin
                mul_a    <= sel_a;
                mul_b    <= sel_b;
                issue_id <= accept_id;
                rr_last  <= accept_id;
            end
        end
    end

    assign tag_in = '{valid: mul_valid, id: issue_id};

    fp16_tag_pipe #(
        .DEPTH (MUL_LAT)
    ) u_tag_pipe (
        .clock   (clock),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // The tag leaving the pipe lines up with mul_result in the same cycle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            req_bus.resp_valid <= 2'b00;
            req_bus.resp_data  <= '0;
            last_result        <= '0;
        end else begin
            req_bus.resp_valid <= tag_out.valid ? (tag_out.id ? 2'b10 : 2'b01) : 2'b00;
            if (tag_out.valid) begin
                req_bus.resp_data <= mul_result;
                last_result       <= mul_result;
            end
        end
    end

    // Decrement on the edge that raises resp_valid, so the count peaks at MUL_LAT+1.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            inflight_cnt <= '0;
        end else begin
            case ({|accept, tag_out.valid})
                2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_mult_arbiter.sv
// Directed bench for fp16_mult_arbiter: stimulus pushes hand-computed products
// into a scoreboard, a negedge monitor pops them as responses appear.
module tb_fp16_mult_arbiter;
    import fp16_pkg::*;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;

    typedef struct packed {
        fp16_t a;
        fp16_t b;
        fp16_t p;
    } vec_t;

    typedef struct packed {
        logic  id;
        fp16_t data;
    } exp_t;

    // Exact products: 1*2, 3*3, 5*-2, .5*.5, 6*1.5 and 4*4, -1*-1, 7*2, .75*4, 9*.25
    localparam vec_t ALT0 [5] = '{
        '{16'h3C00, 16'h4000, 16'h4000},
        '{16'h4200, 16'h4200, 16'h4880},
        '{16'h4500, 16'hC000, 16'hC900},
        '{16'h3800, 16'h3800, 16'h3400},
        '{16'h4600, 16'h3E00, 16'h4880}
    };
    localparam vec_t ALT1 [5] = '{
        '{16'h4400, 16'h4400, 16'h4C00},
        '{16'hBC00, 16'hBC00, 16'h3C00},
        '{16'h4700, 16'h4000, 16'h4B00},
        '{16'h3A00, 16'h4400, 16'h4200},
        '{16'h4880, 16'h3400, 16'h4080}
    };

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             hold  = 1'b0;
    logic             mul_valid;
    fp16_t            mul_a;
    fp16_t            mul_b;
    fp16_t            mul_result;
    fp16_t            last_result;
    logic [CNT_W-1:0] inflight_cnt;

    fp16_mult_arbiter_if bus ();

    fp16_mult_arbiter #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .req_bus      (bus),
        .hold         (hold),
        .mul_valid    (mul_valid),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_result   (mul_result),
        .last_result  (last_result),
        .inflight_cnt (inflight_cnt)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int resp_seen   = 0;
    int peak_cnt    = 0;

    fp16_t va0 [$];
    fp16_t vb0 [$];
    fp16_t va1 [$];
    fp16_t vb1 [$];
    exp_t  sb [$];
    exp_t  mon_e;
    int    grant_id [$];
    int    grant_cyc [$];
    int    resp_cyc [$];

    always @(posedge clock) cycle <= cycle + 1;

    // Normal-range FP16 multiply with round-to-nearest-even.
    function automatic fp16_t fp16_mul(input fp16_t a, input fp16_t b);
        logic        sign;
        int          e;
        logic [21:0] prod;
        logic [9:0]  mant;
        logic        guard;
        logic        sticky;
        logic [10:0] mr;
        sign = a[15] ^ b[15];
        if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {sign, 15'd0};
        prod = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e    = int'(a[14:10]) + int'(b[14:10]) - EXP_BIAS;
        if (prod[21]) begin
            e++;
            mant   = prod[20:11];
            guard  = prod[10];
            sticky = |prod[9:0];
        end else begin
            mant   = prod[19:10];
            guard  = prod[9];
            sticky = |prod[8:0];
        end
        mr = {1'b0, mant} + 11'(guard & (sticky | mant[0]));
        if (mr[10]) e++;
        return {sign, e[4:0], mr[9:0]};
    endfunction

    fp16_t prod_pipe [MUL_LAT];

    always @(posedge clock) begin
        prod_pipe[0] <= mul_valid ? fp16_mul(mul_a, mul_b) : 16'hDEAD;
        for (int i = 1; i < MUL_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
    end

    assign mul_result = prod_pipe[MUL_LAT-1];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    always @(negedge clock) begin
        if (rst_n) begin
            if (int'(inflight_cnt) > peak_cnt) peak_cnt = int'(inflight_cnt);
            if (bus.resp_valid != 2'b00) begin
                resp_seen++;
                resp_cyc.push_back(cycle);
                if (sb.size() == 0) begin
                    check_output("unexpected_resp", 32'(bus.resp_valid), 'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("resp_valid", 32'(bus.resp_valid), mon_e.id ? 'h2 : 'h1);
                    check_output("resp_data", 32'(bus.resp_data), 32'(mon_e.data));
                    check_output("last_result", 32'(last_result), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic drive_reqs();
        bus.req_valid = {va1.size() != 0, va0.size() != 0};
        bus.req_a0    = (va0.size() != 0) ? va0[0] : 16'h0000;
        bus.req_b0    = (vb0.size() != 0) ? vb0[0] : 16'h0000;
        bus.req_a1    = (va1.size() != 0) ? va1[0] : 16'h0000;
        bus.req_b1    = (vb1.size() != 0) ? vb1[0] : 16'h0000;
    endtask

    task automatic apply_stimulus(input int n);
        logic [1:0] acc;
        for (int k = 0; k < n; k++) begin
            drive_reqs();
            @(negedge clock);
            acc = bus.req_valid & bus.req_ready;
            if (acc[0]) begin grant_id.push_back(0); grant_cyc.push_back(cycle); end
            if (acc[1]) begin grant_id.push_back(1); grant_cyc.push_back(cycle); end
            @(posedge clock);
            #1;
            if (acc[0]) begin void'(va0.pop_front()); void'(vb0.pop_front()); end
            if (acc[1]) begin void'(va1.pop_front()); void'(vb1.pop_front()); end
        end
        drive_reqs();
    endtask

    task automatic push_req(input bit id, input fp16_t a, input fp16_t b);
        if (id) begin va1.push_back(a); vb1.push_back(b); end
        else    begin va0.push_back(a); vb0.push_back(b); end
    endtask

    task automatic expect_resp(input bit id, input fp16_t data);
        sb.push_back('{id: id, data: data});
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clock);
        check_output("drain_timeout", 32'(sb.size()), 'h0);
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        sb.delete();
        @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int lat;
        int g0;
        int r0;
        int rel_cyc;

        bus.req_valid = 2'b00;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
        repeat (2) @(posedge clock);
        #1;
        check_output("rst_mul_valid", 32'(mul_valid), 'h0);
        check_output("rst_mul_a", 32'(mul_a), 'h0);
        check_output("rst_mul_b", 32'(mul_b), 'h0);
        check_output("rst_resp_valid", 32'(bus.resp_valid), 'h0);
        check_output("rst_resp_data", 32'(bus.resp_data), 'h0);
        check_output("rst_last_result", 32'(last_result), 'h0);
        check_output("rst_inflight", 32'(inflight_cnt), 'h0);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        // Single request: 4.5 * -0.5 = -2.25
        push_req(0, 16'h4480, 16'hB800);
        expect_resp(0, 16'hC080);
        apply_stimulus(1);
        check_output("t1_mul_valid", 32'(mul_valid), 'h1);
        check_output("t1_mul_a", 32'(mul_a), 'h4480);
        check_output("t1_mul_b", 32'(mul_b), 'hB800);
        check_output("t1_inflight", 32'(inflight_cnt), 'h1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (bus.resp_valid[0]) begin
                lat = k;
                break;
            end
        end
        check_output("t1_latency", 32'(lat), 'h6);
        @(posedge clock);
        #1;
        @(negedge clock);
        check_output("t1_resp_clear", 32'(bus.resp_valid), 'h0);
        check_output("t1_resp_hold", 32'(bus.resp_data), 'hC080);
        check_output("t1_inflight_end", 32'(inflight_cnt), 'h0);
        check_output("t1_last_result", 32'(last_result), 'hC080);
        @(posedge clock);
        #1;

        // Contention from reset; 4.0977*5.5 = 22.537 rounds to 0x4DA2
        reset_dut();
        push_req(0, 16'h4419, 16'h4580);
        push_req(1, 16'hC419, 16'h4580);
        expect_resp(0, 16'h4DA2);
        expect_resp(1, 16'hCDA2);
        g0 = grant_id.size();
        r0 = resp_cyc.size();
        apply_stimulus(3);
        check_output("t2_grants", 32'(grant_id.size() - g0), 'h2);
        if (grant_id.size() >= g0 + 2) begin
            check_output("t2_first_grant", 32'(grant_id[g0]), 'h0);
            check_output("t2_second_grant", 32'(grant_id[g0+1]), 'h1);
            check_output("t2_grant_gap", 32'(grant_cyc[g0+1] - grant_cyc[g0]), 'h1);
        end
        wait_drain();
        check_output("t2_resp_count", 32'(resp_cyc.size() - r0), 'h2);
        if (resp_cyc.size() >= r0 + 2)
            check_output("t2_resp_gap", 32'(resp_cyc[r0+1] - resp_cyc[r0]), 'h1);

        // Sustained alternation over ten cycles
        for (int i = 0; i < 5; i++) begin
            push_req(0, ALT0[i].a, ALT0[i].b);
            push_req(1, ALT1[i].a, ALT1[i].b);
            expect_resp(0, ALT0[i].p);
            expect_resp(1, ALT1[i].p);
        end
        peak_cnt = 0;
        g0 = grant_id.size();
        apply_stimulus(10);
        check_output("t3_grants", 32'(grant_id.size() - g0), 'd10);
        for (int i = 0; i < 10; i++) begin
            if (grant_id.size() > g0 + i)
                check_output("t3_grant_order", 32'(grant_id[g0+i]), 32'(i % 2));
        end
        wait_drain();
        check_output("t3_peak_inflight", 32'(peak_cnt), 'h5);
        check_output("t3_inflight_end", 32'(inflight_cnt), 'h0);

        // hold with two in flight and req1 still pending
        push_req(0, 16'h4000, 16'h4000);
        push_req(1, 16'h4200, 16'h4000);
        push_req(1, 16'hC200, 16'h4200);
        expect_resp(0, 16'h4400);
        expect_resp(1, 16'h4600);
        expect_resp(1, 16'hC880);
        apply_stimulus(2);
        hold = 1'b1;
        r0 = resp_seen;
        g0 = grant_id.size();
        @(negedge clock);
        check_output("t4_ready_held", 32'(bus.req_ready), 'h0);
        check_output("t4_inflight", 32'(inflight_cnt), 'h2);
        @(posedge clock);
        #1;
        apply_stimulus(10);
        check_output("t4_no_grant", 32'(grant_id.size() - g0), 'h0);
        check_output("t4_drained", 32'(resp_seen - r0), 'h2);
        check_output("t4_inflight_zero", 32'(inflight_cnt), 'h0);
        hold = 1'b0;
        rel_cyc = cycle;
        apply_stimulus(1);
        check_output("t4_release_grants", 32'(grant_id.size() - g0), 'h1);
        if (grant_id.size() > g0) begin
            check_output("t4_release_id", 32'(grant_id[g0]), 'h1);
            check_output("t4_release_cycle", 32'(grant_cyc[g0]), 32'(rel_cyc));
        end
        wait_drain();

        // Reset with three operations in flight
        push_req(0, 16'h3C00, 16'h3C00);
        push_req(0, 16'h4000, 16'h3C00);
        push_req(1, 16'h4200, 16'h3C00);
        apply_stimulus(3);
        check_output("t5_inflight", 32'(inflight_cnt), 'h3);
        rst_n = 1'b0;
        #1;
        check_output("t5_mul_valid", 32'(mul_valid), 'h0);
        check_output("t5_mul_a", 32'(mul_a), 'h0);
        check_output("t5_inflight_rst", 32'(inflight_cnt), 'h0);
        check_output("t5_resp_valid", 32'(bus.resp_valid), 'h0);
        check_output("t5_resp_data", 32'(bus.resp_data), 'h0);
        check_output("t5_last_result", 32'(last_result), 'h0);
        @(negedge clock);
        rst_n = 1'b1;
        r0 = resp_seen;
        repeat (10) @(negedge clock);
        check_output("t5_no_resp", 32'(resp_seen - r0), 'h0);
        check_output("t5_inflight_after", 32'(inflight_cnt), 'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish, limit 100000");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
